// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencing controller for a wait-state data memory
// Accepts one memory op at a time, drives a req/gnt/rvalid access and returns extended load data.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [5:0]  aluOP,
  input  logic [31:0] addr,
  input  logic [31:0] rs2,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'd0;
  localparam logic [5:0] OP_LH  = 6'd1;
  localparam logic [5:0] OP_LW  = 6'd2;
  localparam logic [5:0] OP_LBU = 6'd3;
  localparam logic [5:0] OP_LHU = 6'd4;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [5:0]     op_q, op_d;
  logic [1:0]     off_q, off_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mis_q, mis_d;
  logic           berr_q, berr_d;
  logic [31:0]    load_data_q, load_data_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [3:0]     mem_be_q, mem_be_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic           mem_we_q, mem_we_d;

  logic           in_set, is_byte, is_half, is_word, is_store, accept, bad_align;
  logic           q_is_load, timeout;
  logic [31:0]    rd_shift, load_ext;

  always_comb begin
    is_byte  = (aluOP == OP_LB) || (aluOP == OP_LBU) || (aluOP == OP_SB);
    is_half  = (aluOP == OP_LH) || (aluOP == OP_LHU) || (aluOP == OP_SH);
    is_word  = (aluOP == OP_LW) || (aluOP == OP_SW);
    is_store = (aluOP == OP_SB) || (aluOP == OP_SH) || (aluOP == OP_SW);
    in_set   = is_byte || is_half || is_word;
    accept   = (state_q == IDLE) && op_valid && in_set;
    bad_align = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  end

  // Extract the addressed lane from the returned word, then extend per latched op.
  always_comb begin
    rd_shift  = mem_rdata >> {off_q, 3'b000};
    q_is_load = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW) ||
                (op_q == OP_LBU) || (op_q == OP_LHU);
    case (op_q)
      OP_LB:   load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OP_LBU:  load_ext = {24'h0, rd_shift[7:0]};
      OP_LH:   load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      OP_LHU:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mis_d       = mis_q;
    berr_d      = berr_q;
    load_data_d = load_data_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    timeout     = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        mis_d  = 1'b0;
        berr_d = 1'b0;
        if (accept) begin
          op_d       = aluOP;
          off_d      = addr[1:0];
          mem_addr_d = {addr[31:2], 2'b00};
          mem_we_d   = is_store;
          if (is_byte) begin
            mem_be_d    = 4'b0001 << addr[1:0];
            mem_wdata_d = {4{rs2[7:0]}};
          end else if (is_half) begin
            mem_be_d    = 4'b0011 << addr[1:0];
            mem_wdata_d = {2{rs2[15:0]}};
          end else begin
            mem_be_d    = 4'b1111;
            mem_wdata_d = rs2;
          end
          if (bad_align) begin
            state_d     = DONE;
            mis_d       = 1'b1;
            load_data_d = 32'h0;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt && mem_rvalid) begin
          state_d = DONE;
          if (q_is_load) load_data_d = load_ext;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end else if (timeout) begin
          state_d     = DONE;
          berr_d      = 1'b1;
          load_data_d = 32'h0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d = DONE;
          if (q_is_load) load_data_d = load_ext;
        end else if (timeout) begin
          state_d     = DONE;
          berr_d      = 1'b1;
          load_data_d = 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 6'h0;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
      load_data_q <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mis_q       <= mis_d;
      berr_q      <= berr_d;
      load_data_q <= load_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign stall      = accept || (state_q == REQ) || (state_q == WAIT);
  assign done       = (state_q == DONE);
  assign misaligned = done && mis_q;
  assign bus_error  = done && berr_q;
  assign mem_req    = (state_q == REQ);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
// Each task drives one scenario and compares against hand-computed values.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [5:0]  aluOP = 6'd63;
  logic [31:0] addr = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        stall, done, misaligned, bus_error;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .aluOP(aluOP), .addr(addr), .rs2(rs2),
    .stall(stall), .done(done), .load_data(load_data), .misaligned(misaligned),
    .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    op_valid = 1'b1;
    aluOP    = op;
    addr     = a;
    rs2      = d;
    #1;
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0;
    aluOP    = 6'd63;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({stall, done, misaligned, bus_error, mem_req, mem_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {stall, done, misaligned, bus_error, mem_req, mem_we});
    end
    n_checks++;
    if ({load_data, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h expected zeros",
                         load_data, mem_addr, mem_wdata, mem_be);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lb();
    int stall_low = 0;
    issue(6'd0, 32'h0000_1003, 32'h0);
    if (!stall) stall_low++;
    tick(); idle_inputs();
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'b1000, 32'h0000_1000}) begin
      n_fail++; $display("FAIL lb_req: got req=%b we=%b be=%b addr=%h expected 1 0 1000 00001000",
                         mem_req, mem_we, mem_be, mem_addr);
    end
    if (!stall) stall_low++;
    tick();
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL lb_req_hold: got %b expected 1", mem_req);
    end
    if (!stall) stall_low++;
    mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0;
    n_checks++;
    if ({mem_req, done} !== 2'b00) begin
      n_fail++; $display("FAIL lb_wait: got req/done %b expected 00", {mem_req, done});
    end
    if (!stall) stall_low++;
    tick();
    if (!stall) stall_low++;
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_checks++;
    if ({done, stall, load_data} !== {1'b1, 1'b0, 32'hFFFF_FF80}) begin
      n_fail++; $display("FAIL lb_done: got done=%b stall=%b data=%h expected 1 0 ffffff80",
                         done, stall, load_data);
    end
    n_checks++;
    if (stall_low !== 0) begin
      n_fail++; $display("FAIL lb_stall: got %0d low cycles expected 0", stall_low);
    end
    tick();
    n_checks++;
    if ({done, load_data} !== {1'b0, 32'hFFFF_FF80}) begin
      n_fail++; $display("FAIL lb_hold: got done=%b data=%h expected 0 ffffff80", done, load_data);
    end
  endtask

  task automatic test_half_loads();
    issue(6'd4, 32'h0000_2002, 32'h0);
    tick(); idle_inputs();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
    #1;
    n_checks++;
    if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'b1100, 32'h0000_2000}) begin
      n_fail++; $display("FAIL lhu_req: got req=%b be=%b addr=%h expected 1 1100 00002000",
                         mem_req, mem_be, mem_addr);
    end
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
    n_checks++;
    if ({done, load_data} !== {1'b1, 32'h0000_BEEF}) begin
      n_fail++; $display("FAIL lhu_done: got done=%b data=%h expected 1 0000beef", done, load_data);
    end
    tick();
    // back-to-back: accepted in the first IDLE cycle after DONE
    issue(6'd1, 32'h0000_2002, 32'h0);
    tick(); idle_inputs();
    mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_checks++;
    if ({done, load_data} !== {1'b1, 32'hFFFF_BEEF}) begin
      n_fail++; $display("FAIL lh_done: got done=%b data=%h expected 1 ffffbeef", done, load_data);
    end
    tick();
  endtask

  task automatic test_stores();
    issue(6'd16, 32'h0000_3002, 32'hAAAA_1357);
    tick(); idle_inputs();
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_wdata, mem_addr} !==
        {1'b1, 1'b1, 4'b1100, 32'h1357_1357, 32'h0000_3000}) begin
      n_fail++; $display("FAIL sh_req: got req=%b we=%b be=%b wd=%h addr=%h expected 1 1 1100 13571357 00003000",
                         mem_req, mem_we, mem_be, mem_wdata, mem_addr);
    end
    mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0;
    tick();
    n_checks++;
    if ({done, stall} !== 2'b01) begin
      n_fail++; $display("FAIL sh_no_early_done: got done/stall %b expected 01", {done, stall});
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_checks++;
    if ({done, misaligned, bus_error, load_data} !== {3'b100, 32'hFFFF_BEEF}) begin
      n_fail++; $display("FAIL sh_done: got %b data=%h expected 100 ffffbeef",
                         {done, misaligned, bus_error}, load_data);
    end
    tick();
    issue(6'd15, 32'h0000_5001, 32'h1234_5678);
    tick(); idle_inputs();
    n_checks++;
    if ({mem_be, mem_wdata, mem_we} !== {4'b0010, 32'h7878_7878, 1'b1}) begin
      n_fail++; $display("FAIL sb_req: got be=%b wd=%h we=%b expected 0010 78787878 1",
                         mem_be, mem_wdata, mem_we);
    end
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    int req_seen = 0;
    issue(6'd2, 32'h0000_4001, 32'h0);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL mis_accept_stall: got %b expected 1", stall);
    end
    tick(); idle_inputs();
    if (mem_req) req_seen++;
    n_checks++;
    if ({done, misaligned, bus_error, stall, load_data} !== {4'b1100, 32'h0}) begin
      n_fail++; $display("FAIL mis_done: got %b data=%h expected 1100 00000000",
                         {done, misaligned, bus_error, stall}, load_data);
    end
    tick();
    if (mem_req) req_seen++;
    n_checks++;
    if (req_seen !== 0) begin
      n_fail++; $display("FAIL mis_no_req: got %0d req cycles expected 0", req_seen);
    end
    issue(6'd5, 32'h0000_4000, 32'h0);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL nonmem_stall: got %b expected 0", stall);
    end
    tick(); tick();
    n_checks++;
    if ({mem_req, done, stall} !== 3'b000) begin
      n_fail++; $display("FAIL nonmem_idle: got %b expected 000", {mem_req, done, stall});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    logic got_done = 1'b0;
    issue(6'd17, 32'h0000_6000, 32'hDEAD_BEEF);
    tick(); idle_inputs();
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (mem_req) req_cycles++;
      tick();
    end
    n_checks++;
    if (got_done !== 1'b1) begin
      n_fail++; $display("FAIL to_done_seen: got %b expected 1", got_done);
    end
    n_checks++;
    if (req_cycles !== 15) begin
      n_fail++; $display("FAIL to_req_cycles: got %0d expected 15", req_cycles);
    end
    n_checks++;
    if ({bus_error, misaligned, load_data} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL to_flags: got be=%b mis=%b data=%h expected 1 0 00000000",
                         bus_error, misaligned, load_data);
    end
    tick();
    issue(6'd17, 32'h0000_6004, 32'h0BAD_F00D);
    tick(); idle_inputs();
    mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    tick(); mem_rvalid = 1'b0;
    n_checks++;
    if ({done, bus_error, mem_wdata, mem_addr} !== {2'b10, 32'h0BAD_F00D, 32'h0000_6004}) begin
      n_fail++; $display("FAIL sw_after_to: got done=%b be=%b wd=%h addr=%h expected 1 0 0badf00d 00006004",
                         done, bus_error, mem_wdata, mem_addr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(6'd2, 32'h0000_7000, 32'h0);
    tick(); idle_inputs();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, stall, done} !== 3'b000) begin
      n_fail++; $display("FAIL rst_in_req: got %b expected 000", {mem_req, stall, done});
    end
    tick(); rst = 1'b0;
    issue(6'd0, 32'h0000_7000, 32'h0);
    tick(); idle_inputs();
    mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, stall, done} !== 3'b000) begin
      n_fail++; $display("FAIL rst_in_wait: got %b expected 000", {mem_req, stall, done});
    end
    tick(); rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick(); mem_rvalid = 1'b0;
    n_checks++;
    if ({done, mem_req, stall, load_data} !== {3'b000, 32'h0}) begin
      n_fail++; $display("FAIL rst_stray_rvalid: got %b data=%h expected 000 00000000",
                         {done, mem_req, stall}, load_data);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_late_done: got %b expected 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_half_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
